// File: rtl/flag_pulse_conditioner.sv
// Synchronises and deglitches an async line, then issues edge events as rate-limited single-cycle flags.
// Idle latency sig_in -> pulse_out is SYNC_STAGES+FILTER_LEN+1 clocks; surplus events queue in a saturating counter.
`timescale 1ns/1ps
module flag_pulse_conditioner #(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 4,
   parameter int EDGE_SEL    = 0,
   parameter int HOLDOFF     = 4,
   parameter int PEND_W      = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              sig_in,
   input  logic              clr_overflow,
   output logic              pulse_out,
   output logic              level_out,
   output logic [PEND_W-1:0] pending,
   output logic              overflow
);
   localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam int HW = $clog2(HOLDOFF);
   localparam logic [FW-1:0]     FLT_LAST  = FW'(FILTER_LEN - 1);
   localparam logic [HW-1:0]     HOLD_LOAD = HW'(HOLDOFF - 1);
   localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_out;
   logic [FW-1:0]          flt_cnt;
   logic [HW-1:0]          hold_cnt;
   logic                   differ;
   logic                   flt_hit;
   logic                   evt;
   logic                   issue;
   logic                   lost;

   assign sync_out = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      end
   end

   // flt_hit marks the edge on which level_out flips; events are taken from it directly
   always_comb begin
      differ  = (sync_out != level_out);
      flt_hit = differ && (flt_cnt == FLT_LAST);
      evt     = 1'b0;
      case (EDGE_SEL)
         0:       evt = flt_hit && !level_out;
         1:       evt = flt_hit && level_out;
         default: evt = flt_hit;
      endcase
      issue = enable && (pending != '0) && (hold_cnt == '0);
      lost  = enable && evt && !issue && (pending == PEND_MAX);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flt_cnt   <= '0;
         level_out <= 1'b0;
      end else if (!differ) begin
         flt_cnt <= '0;
      end else if (flt_hit) begin
         flt_cnt   <= '0;
         level_out <= ~level_out;
      end else begin
         flt_cnt <= flt_cnt + FW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= '0;
      end else if (!enable) begin
         pending <= '0;
      end else if (evt && issue) begin
         pending <= pending;
      end else if (evt) begin
         if (pending != PEND_MAX) begin
            pending <= pending + PEND_W'(1);
         end
      end else if (issue) begin
         pending <= pending - PEND_W'(1);
      end
   end

   // holdoff keeps running with enable low so re-enabling cannot shorten the spacing
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt  <= '0;
         pulse_out <= 1'b0;
      end else begin
         pulse_out <= issue;
         if (issue) begin
            hold_cnt <= HOLD_LOAD;
         end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - HW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow <= 1'b0;
      end else if (lost) begin
         overflow <= 1'b1;
      end else if (clr_overflow) begin
         overflow <= 1'b0;
      end
   end
endmodule
